// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
// Holds the in-flight writer entry layout and the forward-select encoding.
package pipe_pkg;

  // Entry fields are sized for the widest supported register file; narrower
  // register addresses are zero-extended into rd.
  localparam int unsigned MAX_REG_AW = 8;
  localparam int unsigned IDX_W      = 8;

  localparam int unsigned FWD_RF     = 0;
  localparam int unsigned FWD_ENTRY0 = 1;

  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] rd;
    logic [IDX_W-1:0]      ready_idx;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  // Bits needed to encode values 0 .. value-1, never less than one.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((32'd1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/pipe_fwd_match.sv
// Per-operand forwarding match: finds the youngest in-flight writer of the
// source register and decides between forwarding from it or stalling.
module pipe_fwd_match
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned FW     = 2
) (
  input  logic [REG_AW-1:0]        src,
  input  logic                     use_src,
  input  logic [DEPTH*ENTRY_W-1:0] entries,
  output logic [FW-1:0]            fwd,
  output logic                     hazard
);

  entry_t [DEPTH-1:0] ent;

  assign ent = entries;

  // Scan oldest to youngest so the youngest matching writer has the last word.
  always_comb begin
    fwd    = FW'(FWD_RF);
    hazard = 1'b0;
    if (use_src && (src != '0)) begin
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (ent[k].valid && (ent[k].rd == MAX_REG_AW'(src))) begin
          if (k >= int'(ent[k].ready_idx)) begin
            fwd    = FW'(k + int'(FWD_ENTRY0));
            hazard = 1'b0;
          end else begin
            fwd    = FW'(FWD_RF);
            hazard = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard scoreboard beside the ID stage: tracks in-flight writers and one
// outstanding MDU op, producing forward selects, stall and flush controls.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned ALU_READY  = 0,
  parameter int unsigned LOAD_READY = 1,
  parameter int unsigned MDU_LAT    = 4
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          id_valid,
  input  logic [REG_AW-1:0]             id_rs,
  input  logic [REG_AW-1:0]             id_rt,
  input  logic                          id_use_rs,
  input  logic                          id_use_rt,
  input  logic                          id_wreg,
  input  logic [REG_AW-1:0]             id_rd,
  input  logic                          id_m2reg,
  input  logic                          id_mdu,
  input  logic                          id_redirect,
  output logic [clog2(DEPTH+1)-1:0]     fwda,
  output logic [clog2(DEPTH+1)-1:0]     fwdb,
  output logic                          wpcir,
  output logic                          bubble,
  output logic                          if_flush,
  output logic                          mdu_busy
);

  localparam int unsigned FW = clog2(DEPTH + 1);
  localparam int unsigned CW = clog2(MDU_LAT + 1);

  entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [CW-1:0]      mdu_cnt_q, mdu_cnt_d;
  logic [REG_AW-1:0]  mdu_rd_q, mdu_rd_d;

  logic hazard_a, hazard_b;
  logic mdu_raw_rs, mdu_raw_rt, mdu_waw, mdu_hazard;
  logic stall, issue;

  pipe_fwd_match #(
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH),
    .FW     (FW)
  ) u_match_a (
    .src     (id_rs),
    .use_src (id_use_rs),
    .entries (entries_q),
    .fwd     (fwda),
    .hazard  (hazard_a)
  );

  pipe_fwd_match #(
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH),
    .FW     (FW)
  ) u_match_b (
    .src     (id_rt),
    .use_src (id_use_rt),
    .entries (entries_q),
    .fwd     (fwdb),
    .hazard  (hazard_b)
  );

  assign mdu_busy = (mdu_cnt_q != '0);

  // MDU results are never forwarded, so any touch of its destination waits.
  assign mdu_raw_rs = id_use_rs && (id_rs != '0) && (id_rs == mdu_rd_q);
  assign mdu_raw_rt = id_use_rt && (id_rt != '0) && (id_rt == mdu_rd_q);
  assign mdu_waw    = id_wreg && (id_rd == mdu_rd_q);
  assign mdu_hazard = mdu_busy && (mdu_raw_rs || mdu_raw_rt || mdu_waw || id_mdu);

  assign stall    = id_valid && (hazard_a || hazard_b || mdu_hazard);
  assign issue    = id_valid && !stall;
  assign wpcir    = !stall;
  assign bubble   = stall;
  assign if_flush = id_valid && id_redirect && !stall;

  always_comb begin
    entries_d = '0;
    if (issue && id_wreg && (id_rd != '0) && !id_mdu) begin
      entries_d[0].valid     = 1'b1;
      entries_d[0].rd        = MAX_REG_AW'(id_rd);
      entries_d[0].ready_idx = id_m2reg ? IDX_W'(LOAD_READY) : IDX_W'(ALU_READY);
    end
    for (int k = 1; k < int'(DEPTH); k++) begin
      entries_d[k] = entries_q[k-1];
    end
  end

  // An issue can only happen when the counter is already zero, so the reload
  // never collides with the decrement.
  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    mdu_rd_d  = mdu_rd_q;
    if (mdu_busy) begin
      mdu_cnt_d = mdu_cnt_q - CW'(1);
    end
    if (issue && id_mdu && (id_rd != '0)) begin
      mdu_cnt_d = CW'(MDU_LAT);
      mdu_rd_d  = id_rd;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      entries_q <= '0;
      mdu_cnt_q <= '0;
      mdu_rd_q  <= '0;
    end else begin
      entries_q <= entries_d;
      mdu_cnt_q <= mdu_cnt_d;
      mdu_rd_q  <= mdu_rd_d;
    end
  end

endmodule
